// File: rtl/alu_cmd_if.sv
// Command and response stream bundle between a host and alu_cmd_driver.
// The host side uses the master modport; the driver uses the slave modport.
interface alu_cmd_if #(
  parameter int DATA_W = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic [2:0]          cmd_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2*DATA_W-1:0] rsp_result;
  logic [2:0]          rsp_op;
  logic                rsp_timeout;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Buffers host commands in a FIFO and drives a start/done ALU one command at a time.
// Optional statistics counters are built when ALU_DRV_STATS_EN is defined.
module alu_cmd_driver #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_cmd_if.slave            host,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_op,
  output logic                alu_start,
  output logic                alu_reset_n,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                busy,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_timeouts
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * DATA_W;
  localparam int EW = RW + 3;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NOP, RST, RESP} state_t;

  state_t state_reg, state_next;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic              run_reg;
  logic              empty, full, cmd_ready, push, pop;
  logic [EW-1:0]     head;
  logic [2:0]        head_op;
  logic [DATA_W-1:0] head_a, head_b;

  logic [DATA_W-1:0] alu_a_reg, alu_a_next, alu_b_reg, alu_b_next;
  logic [2:0]        alu_op_reg, alu_op_next;
  logic              alu_start_reg, alu_start_next;
  logic              alu_reset_n_reg, alu_reset_n_next;
  logic [15:0]       wait_cnt_reg, wait_cnt_next;
  logic              rst_cnt_reg, rst_cnt_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [RW-1:0]     rsp_result_reg, rsp_result_next;
  logic [2:0]        rsp_op_reg, rsp_op_next;
  logic              rsp_timeout_reg, rsp_timeout_next;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign cmd_ready = run_reg && !full;
  assign push      = host.cmd_valid && cmd_ready;
  assign pop       = (state_reg == IDLE) && !empty;
  assign head      = mem[rd_ptr_reg[AW-1:0]];
  assign {head_op, head_a, head_b} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {host.cmd_op, host.cmd_a, host.cmd_b};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg         <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      state_reg       <= IDLE;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= '0;
      alu_start_reg   <= 1'b0;
      alu_reset_n_reg <= 1'b0;
      wait_cnt_reg    <= '0;
      rst_cnt_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_result_reg  <= '0;
      rsp_op_reg      <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      run_reg         <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      state_reg       <= state_next;
      alu_a_reg       <= alu_a_next;
      alu_b_reg       <= alu_b_next;
      alu_op_reg      <= alu_op_next;
      alu_start_reg   <= alu_start_next;
      alu_reset_n_reg <= alu_reset_n_next;
      wait_cnt_reg    <= wait_cnt_next;
      rst_cnt_reg     <= rst_cnt_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_result_reg  <= rsp_result_next;
      rsp_op_reg      <= rsp_op_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    alu_a_next       = alu_a_reg;
    alu_b_next       = alu_b_reg;
    alu_op_next      = alu_op_reg;
    alu_start_next   = alu_start_reg;
    alu_reset_n_next = 1'b1;
    wait_cnt_next    = wait_cnt_reg;
    rst_cnt_next     = rst_cnt_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_result_next  = rsp_result_reg;
    rsp_op_next      = rsp_op_reg;
    rsp_timeout_next = rsp_timeout_reg;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          alu_a_next  = head_a;
          alu_b_next  = head_b;
          alu_op_next = head_op;
          case (head_op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
              alu_start_next = 1'b1;
              state_next     = ISSUE;
            end
            OP_RST: begin
              alu_start_next   = 1'b0;
              alu_reset_n_next = 1'b0;
              rst_cnt_next     = 1'b0;
              state_next       = RST;
            end
            default: begin
              alu_start_next = 1'b1;
              state_next     = NOP;
            end
          endcase
        end
      end
      ISSUE: begin
        wait_cnt_next = '0;
        state_next    = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          alu_start_next   = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_result_next  = alu_result;
          rsp_op_next      = alu_op_reg;
          rsp_timeout_next = 1'b0;
          state_next       = RESP;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          alu_start_next   = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_result_next  = '0;
          rsp_op_next      = alu_op_reg;
          rsp_timeout_next = 1'b1;
          state_next       = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
      end
      NOP: begin
        alu_start_next   = 1'b0;
        rsp_valid_next   = 1'b1;
        rsp_result_next  = '0;
        rsp_op_next      = alu_op_reg;
        rsp_timeout_next = 1'b0;
        state_next       = RESP;
      end
      RST: begin
        // ALU reset is held low through the entry edge plus one more cycle.
        if (rst_cnt_reg) begin
          rsp_valid_next   = 1'b1;
          rsp_result_next  = '0;
          rsp_op_next      = OP_RST;
          rsp_timeout_next = 1'b0;
          state_next       = RESP;
        end else begin
          alu_reset_n_next = 1'b0;
          rst_cnt_next     = 1'b1;
        end
      end
      RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign host.cmd_ready   = cmd_ready;
  assign host.rsp_valid   = rsp_valid_reg;
  assign host.rsp_result  = rsp_result_reg;
  assign host.rsp_op      = rsp_op_reg;
  assign host.rsp_timeout = rsp_timeout_reg;
  assign alu_a            = alu_a_reg;
  assign alu_b            = alu_b_reg;
  assign alu_op           = alu_op_reg;
  assign alu_start        = alu_start_reg;
  assign alu_reset_n      = alu_reset_n_reg;
  assign busy             = (state_reg != IDLE) || !empty;

`ifdef ALU_DRV_STATS_EN
  logic        ops_inc, to_inc;
  logic [15:0] stat_ops_reg, stat_timeouts_reg;

  assign ops_inc = (state_reg == WAIT) && alu_done;
  assign to_inc  = (state_reg == WAIT) && !alu_done && (wait_cnt_reg == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_reg      <= '0;
      stat_timeouts_reg <= '0;
    end else begin
      if (ops_inc && stat_ops_reg != 16'hFFFF) stat_ops_reg <= stat_ops_reg + 16'd1;
      if (to_inc && stat_timeouts_reg != 16'hFFFF) stat_timeouts_reg <= stat_timeouts_reg + 16'd1;
    end
  end

  assign stat_ops      = stat_ops_reg;
  assign stat_timeouts = stat_timeouts_reg;
`else
  assign stat_ops      = '0;
  assign stat_timeouts = '0;
`endif
endmodule
